// File: rtl/scope_capture.sv
// Multi-channel capture engine: synchronised probes are written into a circular buffer
// at a divided rate, keeping a programmable amount of pre-trigger history for readback.
module scope_capture #(
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int CW       = 2,
  parameter int DW       = 8
) (
  input  logic                PCI_Clock,
  input  logic                PCI_Reset,
  input  logic [CHANNELS-1:0] ProbeIn,
  input  logic                Arm,
  input  logic                Abort,
  input  logic                ForceTrig,
  input  logic [1:0]          TrigMode,
  input  logic [CW-1:0]       TrigChannel,
  input  logic [AW-1:0]       PreTrig,
  input  logic [DW-1:0]       ClockDiv,
  input  logic [AW-1:0]       ReadAddr,
  output logic [CHANNELS-1:0] ReadData,
  output logic                Busy,
  output logic                Triggered,
  output logic                Done
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE       = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [CHANNELS-1:0] sync1_q, sync2_q;
  logic [CHANNELS-1:0] prev_q, prev_d;
  logic [CHANNELS-1:0] mem_q [DEPTH];
  logic [CHANNELS-1:0] read_data_q, read_data_d;
  logic [DW-1:0]       presc_q, presc_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       start_ptr_q, start_ptr_d;
  logic [AW-1:0]       pre_cnt_q, pre_cnt_d;
  logic [AW-1:0]       post_cnt_q, post_cnt_d;
  logic                first_q, first_d;
  logic                force_q, force_d;
  logic                busy_q, busy_d;
  logic                trig_q, trig_d;
  logic                done_q, done_d;
  logic                strobe_s, mem_we_s, ch_valid_s, cur_bit_s, prev_bit_s, cond_s, fire_s;
  logic [AW-1:0]       post_init_s;

  // Pick the watched channel out of the current and previous sample; out-of-range selects match nothing.
  always_comb begin
    ch_valid_s = 1'b0;
    cur_bit_s  = 1'b0;
    prev_bit_s = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      ch_valid_s = ch_valid_s | (TrigChannel == CW'(i));
      cur_bit_s  = cur_bit_s  | ((TrigChannel == CW'(i)) & sync2_q[i]);
      prev_bit_s = prev_bit_s | ((TrigChannel == CW'(i)) & prev_q[i]);
    end
  end

  // Trigger condition for the current strobe; edges need a previous sample from this capture.
  always_comb begin
    case (TrigMode)
      2'b00:   cond_s = ch_valid_s & ~first_q & ~prev_bit_s & cur_bit_s;
      2'b01:   cond_s = ch_valid_s & ~first_q & prev_bit_s & ~cur_bit_s;
      2'b10:   cond_s = ch_valid_s & cur_bit_s;
      2'b11:   cond_s = ch_valid_s & ~cur_bit_s;
      default: cond_s = 1'b0;
    endcase
  end

  assign strobe_s    = busy_q & (presc_q == ClockDiv);
  assign fire_s      = strobe_s & (cond_s | force_q | ForceTrig);
  assign post_init_s = LAST_IDX - PreTrig;

  // Next-state logic for the capture controller and its counters.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    wr_ptr_d    = wr_ptr_q;
    start_ptr_d = start_ptr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    prev_d      = prev_q;
    first_d     = first_q;
    force_d     = force_q;
    trig_d      = trig_q;
    done_d      = done_q;
    mem_we_s    = 1'b0;

    if (busy_q) begin
      presc_d = strobe_s ? {DW{1'b0}} : presc_q + DW'(1);
    end else begin
      presc_d = presc_q;
    end

    if (strobe_s) begin
      mem_we_s = 1'b1;
      wr_ptr_d = wr_ptr_q + AW'(1);
      prev_d   = sync2_q;
      first_d  = 1'b0;
    end else begin
      mem_we_s = 1'b0;
    end

    // A forced trigger is remembered until the first strobe that is allowed to trigger.
    if (ForceTrig && ((state_q == ST_PRE) || (state_q == ST_WAIT_TRIG))) begin
      force_d = 1'b1;
    end else begin
      force_d = force_q;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Arm) begin
          state_d    = (PreTrig == {AW{1'b0}}) ? ST_WAIT_TRIG : ST_PRE;
          presc_d    = {DW{1'b0}};
          wr_ptr_d   = {AW{1'b0}};
          pre_cnt_d  = {AW{1'b0}};
          post_cnt_d = {AW{1'b0}};
          first_d    = 1'b1;
          force_d    = 1'b0;
          trig_d     = 1'b0;
          done_d     = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_PRE: begin
        if (strobe_s) begin
          pre_cnt_d = pre_cnt_q + AW'(1);
          if ((pre_cnt_q + AW'(1)) == PreTrig) begin
            state_d = ST_WAIT_TRIG;
          end else begin
            state_d = ST_PRE;
          end
        end else begin
          state_d = ST_PRE;
        end
      end
      ST_WAIT_TRIG: begin
        if (fire_s) begin
          trig_d     = 1'b1;
          force_d    = 1'b0;
          post_cnt_d = post_init_s;
          if (post_init_s == {AW{1'b0}}) begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            start_ptr_d = wr_ptr_q + AW'(1);
          end else begin
            state_d = ST_POST;
          end
        end else begin
          state_d = ST_WAIT_TRIG;
        end
      end
      ST_POST: begin
        if (strobe_s) begin
          post_cnt_d = post_cnt_q - AW'(1);
          if (post_cnt_q == AW'(1)) begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            start_ptr_d = wr_ptr_q + AW'(1);
          end else begin
            state_d = ST_POST;
          end
        end else begin
          state_d = ST_POST;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over everything else but leaves the trigger flag and buffer intact.
    if (Abort) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      trig_d  = trig_q;
      force_d = 1'b0;
    end else begin
      done_d  = done_d;
    end

    busy_d = (state_d == ST_PRE) || (state_d == ST_WAIT_TRIG) || (state_d == ST_POST);
  end

  // Readback index 0 maps onto the oldest entry of the finished capture.
  always_comb begin
    read_data_d = mem_q[start_ptr_q + ReadAddr];
  end

  // Control, synchroniser and output registers.
  always_ff @(posedge PCI_Clock) begin
    if (PCI_Reset) begin
      state_q     <= ST_IDLE;
      sync1_q     <= {CHANNELS{1'b0}};
      sync2_q     <= {CHANNELS{1'b0}};
      prev_q      <= {CHANNELS{1'b0}};
      read_data_q <= {CHANNELS{1'b0}};
      presc_q     <= {DW{1'b0}};
      wr_ptr_q    <= {AW{1'b0}};
      start_ptr_q <= {AW{1'b0}};
      pre_cnt_q   <= {AW{1'b0}};
      post_cnt_q  <= {AW{1'b0}};
      first_q     <= 1'b0;
      force_q     <= 1'b0;
      busy_q      <= 1'b0;
      trig_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= ProbeIn;
      sync2_q     <= sync1_q;
      prev_q      <= prev_d;
      read_data_q <= read_data_d;
      presc_q     <= presc_d;
      wr_ptr_q    <= wr_ptr_d;
      start_ptr_q <= start_ptr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      first_q     <= first_d;
      force_q     <= force_d;
      busy_q      <= busy_d;
      trig_q      <= trig_d;
      done_q      <= done_d;
    end
  end

  // Sample buffer; deliberately not cleared by reset.
  always_ff @(posedge PCI_Clock) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q] <= sync2_q;
    end
  end

  assign ReadData  = read_data_q;
  assign Busy      = busy_q;
  assign Triggered = trig_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_scope_capture.sv
// Randomised scoreboard bench for scope_capture: a sample-stream model predicts the
// trigger point, completion time and buffer contents; a monitor checks readback.
module tb_scope_capture;
  localparam int DEPTH = 16;

  logic       PCI_Clock = 1'b0;
  logic       PCI_Reset, Arm, Abort, ForceTrig;
  logic [3:0] ProbeIn;
  logic [1:0] TrigMode, TrigChannel;
  logic [3:0] PreTrig, ReadAddr;
  logic [7:0] ClockDiv;
  logic [3:0] ReadData;
  logic       Busy, Triggered, Done;
  logic [2:0] ReadData3;
  logic       Busy3, Triggered3, Done3;

  scope_capture #(.CHANNELS(4), .DEPTH(16), .AW(4), .CW(2), .DW(8)) u_dut (
    .PCI_Clock(PCI_Clock), .PCI_Reset(PCI_Reset), .ProbeIn(ProbeIn), .Arm(Arm), .Abort(Abort),
    .ForceTrig(ForceTrig), .TrigMode(TrigMode), .TrigChannel(TrigChannel), .PreTrig(PreTrig),
    .ClockDiv(ClockDiv), .ReadAddr(ReadAddr), .ReadData(ReadData), .Busy(Busy),
    .Triggered(Triggered), .Done(Done));

  scope_capture #(.CHANNELS(3), .DEPTH(16), .AW(4), .CW(2), .DW(8)) u_dut3 (
    .PCI_Clock(PCI_Clock), .PCI_Reset(PCI_Reset), .ProbeIn(ProbeIn[2:0]), .Arm(Arm), .Abort(Abort),
    .ForceTrig(ForceTrig), .TrigMode(TrigMode), .TrigChannel(TrigChannel), .PreTrig(PreTrig),
    .ClockDiv(ClockDiv), .ReadAddr(ReadAddr), .ReadData(ReadData3), .Busy(Busy3),
    .Triggered(Triggered3), .Done(Done3));

  always #5 PCI_Clock = ~PCI_Clock;

  int cyc = 0;
  always @(posedge PCI_Clock) cyc <= cyc + 1;

  int         n_chk = 0;
  int         n_pass = 0;
  logic [3:0] hist [0:32767];
  int         pat_mode = 2;
  logic [3:0] pat_val = 4'd0;
  int         cnt_a = 0;
  int         cur_div = 0;
  int         arm_e = 0;
  logic       rd_req = 1'b0;
  logic       rd_vld = 1'b0;
  logic [3:0] exp_data_q[$];
  int         exp_addr_q[$];

  always @(posedge PCI_Clock) rd_vld <= rd_req;

  // Readback monitor: every presented read is compared against the oldest expected entry.
  always @(negedge PCI_Clock) begin
    logic [3:0] e;
    int a;
    if (rd_vld) begin
      n_chk++;
      if (exp_data_q.size() == 0) begin
        $display("FAIL readback: got %0h with no expected entry", ReadData);
      end else begin
        e = exp_data_q.pop_front();
        a = exp_addr_q.pop_front();
        if (ReadData === e) n_pass++;
        else $display("FAIL readback[%0d]: got %0h expected %0h", a, ReadData, e);
      end
    end
  end

  task automatic check(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  // Advance to the next falling edge, drop pulses and present the probe value for the coming edge.
  task automatic next_cycle();
    int t;
    @(negedge PCI_Clock);
    Arm = 1'b0; Abort = 1'b0; ForceTrig = 1'b0;
    t = cyc + 3 - cnt_a;
    case (pat_mode)
      0:       ProbeIn = 4'($urandom);
      1:       ProbeIn = (t >= cur_div + 1) ? 4'(t / (cur_div + 1) - 1) : 4'd0;
      default: ProbeIn = pat_val;
    endcase
    if (cyc + 1 > 32767) begin
      $display("FAIL history_overflow: got cycle %0d limit 32767", cyc);
      $fatal(1);
    end
    hist[cyc + 1] = ProbeIn;
  endtask

  // Sample k of the capture: strobe k lands on clock arm_e+(div+1)(k+1), seeing the probe two clocks earlier.
  function automatic logic [3:0] smp(input int k);
    return hist[arm_e + (cur_div + 1) * (k + 1) - 2];
  endfunction

  task automatic run_capture(input string nm, input int pre, input int div, input int mode,
                             input int ch, input int pat, input logic [3:0] val,
                             input bit force_pre, input bit arm_post, input int chk3);
    int kt, kf, done_e;
    logic [3:0] c, p;
    bit hit, post_armed;
    next_cycle(); Abort = 1'b1;
    next_cycle();
    PreTrig = 4'(pre); ClockDiv = 8'(div); TrigMode = 2'(mode); TrigChannel = 2'(ch);
    cur_div = div; pat_mode = pat; pat_val = val; cnt_a = cyc + 3;
    next_cycle(); next_cycle();
    Arm = 1'b1; arm_e = cyc + 1;
    if (force_pre) begin
      next_cycle(); ForceTrig = 1'b1;
    end
    done_e = -1; post_armed = 1'b0;
    for (int g = 0; g < 3000 && done_e < 0; g++) begin
      next_cycle();
      if (Done) done_e = cyc;
      else if (arm_post && !post_armed && Busy && Triggered) begin
        Arm = 1'b1; post_armed = 1'b1;
      end
    end
    if (done_e < 0) begin
      check({nm, " done_timeout"}, 0, 1);
      return;
    end
    kt = -1;
    for (int k = pre; kt < 0 && arm_e + (div + 1) * (k + 1) <= cyc; k++) begin
      c = smp(k);
      p = (k > 0) ? smp(k - 1) : 4'd0;
      if (force_pre) hit = 1'b1;
      else begin
        case (mode)
          0:       hit = (k > 0) && !p[ch] && c[ch];
          1:       hit = (k > 0) && p[ch] && !c[ch];
          2:       hit = c[ch];
          default: hit = !c[ch];
        endcase
      end
      if (hit) kt = k;
    end
    if (kt < 0) begin
      check({nm, " model_trigger_found"}, 0, 1);
      return;
    end
    kf = kt + DEPTH - 1 - pre;
    check({nm, " done_cycle"}, done_e - arm_e, (div + 1) * (kf + 1));
    check({nm, " triggered"}, int'(Triggered), 1);
    check({nm, " busy_after_done"}, int'(Busy), 0);
    if (chk3 == 1) begin
      check({nm, " ch3dut_triggered"}, int'(Triggered3), 1);
      check({nm, " ch3dut_done"}, int'(Done3), 1);
    end else if (chk3 == 2) begin
      check({nm, " ch3dut_busy"}, int'(Busy3), 1);
      check({nm, " ch3dut_triggered"}, int'(Triggered3), 0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      next_cycle();
      ReadAddr = 4'(i); rd_req = 1'b1;
      exp_data_q.push_back(smp(kt - pre + i));
      exp_addr_q.push_back(i);
    end
    next_cycle(); rd_req = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int pre, div, mode, ch;
    bit seen;
    PCI_Reset = 1'b1; Arm = 1'b0; Abort = 1'b0; ForceTrig = 1'b0; ProbeIn = 4'd0;
    TrigMode = 2'd0; TrigChannel = 2'd0; PreTrig = 4'd0; ClockDiv = 8'd0; ReadAddr = 4'd0;
    next_cycle(); next_cycle();
    PCI_Reset = 1'b0;
    check("reset busy", int'(Busy), 0);
    check("reset done", int'(Done), 0);
    check("reset triggered", int'(Triggered), 0);
    check("reset readdata", int'(ReadData), 0);
    check("reset readdata_ch3dut", int'(ReadData3), 0);

    run_capture("rise_basic", 4, 0, 0, 1, 1, 4'd0, 1'b0, 1'b0, 0);
    run_capture("clkdiv3", 0, 3, 3, 3, 1, 4'd0, 1'b0, 1'b0, 0);
    run_capture("force_badch", 3, 1, 0, 3, 2, 4'b0101, 1'b1, 1'b0, 1);
    run_capture("badch_noforce", 2, 0, 0, 3, 0, 4'd0, 1'b0, 1'b0, 2);
    run_capture("arm_in_post", 4, 1, 2, 0, 0, 4'd0, 1'b0, 1'b1, 0);
    run_capture("fall_pre15", 15, 0, 1, 2, 0, 4'd0, 1'b0, 1'b0, 0);
    run_capture("high_ch0", 2, 1, 2, 0, 2, 4'b0001, 1'b0, 1'b0, 0);
    for (int r = 0; r < 6; r++) begin
      pre = int'($urandom_range(0, 15)); div = int'($urandom_range(0, 2));
      mode = int'($urandom_range(0, 3)); ch = int'($urandom_range(0, 3));
      run_capture($sformatf("rand%0d", r), pre, div, mode, ch, 0, 4'd0, 1'b0, 1'b0, 0);
    end

    // Abort while waiting for a trigger that never comes.
    next_cycle(); Abort = 1'b1;
    next_cycle();
    PreTrig = 4'd2; ClockDiv = 8'd0; TrigMode = 2'b10; TrigChannel = 2'd0;
    pat_mode = 2; pat_val = 4'b0000;
    next_cycle(); next_cycle(); Arm = 1'b1;
    repeat (10) next_cycle();
    check("abort_wait busy_before", int'(Busy), 1);
    check("abort_wait triggered_before", int'(Triggered), 0);
    Abort = 1'b1;
    next_cycle();
    check("abort_wait busy", int'(Busy), 0);
    check("abort_wait done", int'(Done), 0);

    // Abort during POST keeps the trigger flag.
    pat_val = 4'b0001; ClockDiv = 8'd2;
    next_cycle(); next_cycle(); Arm = 1'b1;
    seen = 1'b0;
    for (int g = 0; g < 100 && !seen; g++) begin
      next_cycle();
      seen = Triggered;
    end
    check("abort_post reached_post", int'(seen && Busy), 1);
    Abort = 1'b1;
    next_cycle();
    check("abort_post busy", int'(Busy), 0);
    check("abort_post done", int'(Done), 0);
    check("abort_post triggered_kept", int'(Triggered), 1);

    // Arm and Abort together: Abort wins.
    next_cycle(); Arm = 1'b1; Abort = 1'b1;
    repeat (3) next_cycle();
    check("arm_abort busy", int'(Busy), 0);
    check("arm_abort triggered_kept", int'(Triggered), 1);

    // Reset in the middle of a capture discards it.
    pat_val = 4'b0000; ClockDiv = 8'd0;
    next_cycle(); Arm = 1'b1;
    repeat (5) next_cycle();
    check("midreset busy_before", int'(Busy), 1);
    PCI_Reset = 1'b1;
    next_cycle(); PCI_Reset = 1'b0;
    check("midreset busy", int'(Busy), 0);
    check("midreset triggered", int'(Triggered), 0);

    repeat (3) next_cycle();
    check("scoreboard_drain", exp_data_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
